// File: rtl/shift_arbiter_if.sv
// Request/response/shifter bundle for shift_arbiter: two tagged requesters, one response
// channel and the port pair toward the shared combinational barrel shifter.
interface shift_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [AMT_W-1:0] req0_amount;
  logic             req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req1_amount;
  logic             req1_op;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;

  logic [WIDTH-1:0] sh_data_in;
  logic [AMT_W-1:0] sh_amount;
  logic             sh_op;
  logic [WIDTH-1:0] sh_data_out;

  modport slave (
    input  req0_valid, req0_data, req0_amount, req0_op,
    input  req1_valid, req1_data, req1_amount, req1_op,
    input  rsp_ready, sh_data_out,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    output sh_data_in, sh_amount, sh_op
  );

  modport master (
    output req0_valid, req0_data, req0_amount, req0_op,
    output req1_valid, req1_data, req1_amount, req1_op,
    output rsp_ready, sh_data_out,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  sh_data_in, sh_amount, sh_op
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one external barrel shifter between two requesters.
// Optional macro SHIFT_ARB_ZERO_BYPASS_EN: zero-amount requests skip EXEC (latency 1).
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  shift_arbiter_if.slave   bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] amount_q;
  logic             op_q;
  logic             id_q;
  logic             rr_last_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] done_count_q;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [AMT_W-1:0] sel_amount_s;
  logic             sel_op_s;

  // Grant: a lone requester wins; on a tie the requester not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~rr_last_q;
    end else if (bus.req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign accept_s       = grant_valid_s & (state_q == IDLE);
  assign bus.req0_ready = reset_n_i & accept_s & ~grant_id_s;
  assign bus.req1_ready = reset_n_i & accept_s & grant_id_s;

  assign sel_data_s   = grant_id_s ? bus.req1_data   : bus.req0_data;
  assign sel_amount_s = grant_id_s ? bus.req1_amount : bus.req0_amount;
  assign sel_op_s     = grant_id_s ? bus.req1_op     : bus.req0_op;

  // The shifter only ever sees the latched operands, isolating it from the request ports.
  assign bus.sh_data_in = data_q;
  assign bus.sh_amount  = amount_q;
  assign bus.sh_op      = op_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy_o        = busy_q;
  assign done_count_o  = done_count_q;

  // Sequencer FSM with all of its outputs held in registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      data_q       <= {WIDTH{1'b0}};
      amount_q     <= {AMT_W{1'b0}};
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      rr_last_q    <= 1'b1;
      rsp_data_q   <= {WIDTH{1'b0}};
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_count_q <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            data_q    <= sel_data_s;
            amount_q  <= sel_amount_s;
            op_q      <= sel_op_s;
            id_q      <= grant_id_s;
            rr_last_q <= grant_id_s;
            busy_q    <= 1'b1;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
            if (sel_amount_s == {AMT_W{1'b0}}) begin
              rsp_data_q  <= sel_data_s;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= EXEC;
            end
`else
            state_q <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_data_q  <= bus.sh_data_out;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_count_q <= done_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q      <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic reference of shifts, round-robin order and counts.
module tb_shift_arbiter;
  localparam int WIDTH = 32;
  localparam int AMT_W = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus_if ();
  logic             busy;
  logic [CNT_W-1:0] done_count;

  shift_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .bus         (bus_if),
    .busy_o      (busy),
    .done_count_o(done_count)
  );

  // Behavioural stand-in for the shared combinational barrel shifter.
  logic signed [WIDTH-1:0] sh_signed;
  logic        [WIDTH-1:0] sh_asr;
  assign sh_signed = signed'(bus_if.sh_data_in);
  assign sh_asr    = sh_signed >>> bus_if.sh_amount;
  assign bus_if.sh_data_out = bus_if.sh_op ? sh_asr : (bus_if.sh_data_in << bus_if.sh_amount);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit m_rr_last = 1'b1;
  int m_count = 0;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input bit op);
    longint p;
    longint s;
    longint q;
    logic [63:0] prod;
    p = 1;
    for (int k = 0; k < amt; k++) p = p * 2;
    if (!op) begin
      prod = 64'(longint'(d) * p);
      return prod[31:0];
    end else begin
      s = longint'(signed'(d));
      if (s >= 0) q = s / p;
      else q = -((-s + p - 1) / p);
      prod = 64'(q);
      return prod[31:0];
    end
  endfunction

  task automatic idle_inputs();
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    bus_if.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_rr_last = 1'b1;
    m_count = 0;
  endtask

  // One full transaction: drive, check grant, accept, latency, hold under backpressure, handshake.
  task automatic issue(input bit v0, input bit v1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input bit o0, input bit o1, input int hold,
                       output bit gid, output int acc_cyc, output logic [31:0] got);
    bit          eg;
    logic [31:0] ed;
    logic [4:0]  ea;
    bit          eo;
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    bus_if.req0_valid = v0; bus_if.req0_data = d0; bus_if.req0_amount = a0; bus_if.req0_op = o0;
    bus_if.req1_valid = v1; bus_if.req1_data = d1; bus_if.req1_amount = a1; bus_if.req1_op = o1;
    bus_if.rsp_ready = 1'b0;
    #1;
    eg = (v0 && v1) ? ~m_rr_last : v1;
    checks++;
    if (bus_if.req0_ready !== !eg || bus_if.req1_ready !== eg)
      $display("FAIL grant: ready0=%0b ready1=%0b expected grant to %0d", bus_if.req0_ready, bus_if.req1_ready, eg);
    gid = eg;
    m_rr_last = eg;
    ed = eg ? d1 : d0;
    ea = eg ? a1 : a0;
    eo = eg ? o1 : o0;
    exp_res = ref_shift(ed, int'(ea), eo);
    exp_lat = 2;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
    if (ea == 5'd0) exp_lat = 1;
`endif
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    @(negedge clk);
    if (eg) begin
      bus_if.req1_valid = 1'b0;
      bus_if.req1_data = $urandom;
      bus_if.req1_amount = 5'($urandom_range(0, 31));
    end else begin
      bus_if.req0_valid = 1'b0;
      bus_if.req0_data = $urandom;
      bus_if.req0_amount = 5'($urandom_range(0, 31));
    end
    #1;
    lat = 1;
    while (bus_if.rsp_valid !== 1'b1 && lat < 8) begin
      checks++;
      if (bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL exec_state: ready0=%0b ready1=%0b busy=%0b expected 0 0 1", bus_if.req0_ready, bus_if.req1_ready, busy);
      if (bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0 || busy !== 1'b1) errors++;
      @(negedge clk);
      #1;
      lat++;
    end
    got = bus_if.rsp_data;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d (rsp_valid=%0b)", lat, exp_lat, bus_if.rsp_valid);
    end
    checks++;
    if (bus_if.rsp_data !== exp_res || bus_if.rsp_id !== eg || busy !== 1'b1) begin
      errors++;
      $display("FAIL response: data=%h id=%0b busy=%0b expected data=%h id=%0b busy=1", bus_if.rsp_data, bus_if.rsp_id, busy, exp_res, eg);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus_if.req0_data = $urandom;
      bus_if.req1_data = $urandom;
      bus_if.req0_valid = 1'b1;
      #1;
      checks++;
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== exp_res || bus_if.rsp_id !== eg || busy !== 1'b1 ||
          bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0 || done_count !== CNT_W'(m_count)) begin
        errors++;
        $display("FAIL hold: valid=%0b data=%h id=%0b busy=%0b rdy=%0b%0b count=%0d expected 1 %h %0b 1 00 %0d",
                 bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_id, busy, bus_if.req0_ready, bus_if.req1_ready,
                 done_count, exp_res, eg, m_count);
      end
    end
    if (hold > 0) bus_if.req0_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL handshake_ready: ready0=%0b ready1=%0b expected 0 0", bus_if.req0_ready, bus_if.req1_ready);
    end
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    m_count++;
    #1;
    checks++;
    if (done_count !== CNT_W'(m_count) || bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL complete: count=%0d valid=%0b busy=%0b expected %0d 0 0", done_count, bus_if.rsp_valid, busy, m_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_data = 32'hDEAD_BEEF; bus_if.req0_amount = 5'd3; bus_if.req0_op = 1'b0;
    bus_if.req1_valid = 1'b1; bus_if.req1_data = 32'h1234_0000; bus_if.req1_amount = 5'd1; bus_if.req1_op = 1'b1;
    bus_if.rsp_ready = 1'b0;
    #12;
    checks++;
    if (bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready0=%0b ready1=%0b expected 0 0", bus_if.req0_ready, bus_if.req1_ready);
    end
    checks++;
    if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0 || bus_if.rsp_id !== 1'b0 || bus_if.rsp_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b count=%0d id=%0b data=%h expected all zero",
               bus_if.rsp_valid, busy, done_count, bus_if.rsp_id, bus_if.rsp_data);
    end
    checks++;
    if (bus_if.sh_data_in !== 32'd0 || bus_if.sh_amount !== 5'd0 || bus_if.sh_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_operands: sh_data_in=%h sh_amount=%0d sh_op=%0b expected 0", bus_if.sh_data_in, bus_if.sh_amount, bus_if.sh_op);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_rr_last = 1'b1;
    m_count = 0;
  endtask

  task automatic test_single_left();
    bit g; int c; logic [31:0] r;
    issue(1'b1, 1'b0, 32'h0000_00F1, 32'h0, 5'd4, 5'd0, 1'b0, 1'b0, 0, g, c, r);
    idle_inputs();
    checks++;
    if (r !== 32'h0000_0F10 || g !== 1'b0 || done_count !== 16'd1) begin
      errors++;
      $display("FAIL single_left: data=%h id=%0b count=%0d expected 00000f10 0 1", r, g, done_count);
    end
  endtask

  task automatic test_asr();
    bit g; int c; logic [31:0] r;
    issue(1'b0, 1'b1, 32'h0, 32'h8000_0000, 5'd0, 5'd31, 1'b0, 1'b1, 0, g, c, r);
    idle_inputs();
    checks++;
    if (r !== 32'hFFFF_FFFF || g !== 1'b1) begin
      errors++;
      $display("FAIL asr: data=%h id=%0b expected ffffffff 1", r, g);
    end
  endtask

  task automatic test_round_robin();
    bit g; int c; int prev; logic [31:0] r;
    bit exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, $urandom, $urandom, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, g, c, r);
      checks++;
      if (g !== exp_order[i]) begin
        errors++;
        $display("FAIL rr_order: op %0d granted %0d expected %0d", i, g, exp_order[i]);
      end
      if (i > 0) begin
        checks++;
        if (c - prev != 3) begin
          errors++;
          $display("FAIL throughput: accepts %0d cycles apart expected 3", c - prev);
        end
      end
      prev = c;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    bit g; int c; logic [31:0] r;
    issue(1'b1, 1'b0, 32'hA5A5_0F0F, 32'h0, 5'd8, 5'd0, 1'b1, 1'b0, 5, g, c, r);
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    bit g; int c; logic [31:0] r;
    @(negedge clk);
    bus_if.req0_valid = 1'b1; bus_if.req0_data = 32'h0F0F_0001; bus_if.req0_amount = 5'd2; bus_if.req0_op = 1'b0;
    bus_if.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    bus_if.req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_exec: busy=%0b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.rsp_valid !== 1'b0 || done_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: valid=%0b count=%0d busy=%0b expected 0 0 0", bus_if.rsp_valid, done_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_rr_last = 1'b1;
    m_count = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midop_discard: valid=%0b busy=%0b expected 0 0", bus_if.rsp_valid, busy);
      end
    end
    issue(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0005, 5'd1, 5'd1, 1'b0, 1'b0, 0, g, c, r);
    idle_inputs();
    checks++;
    if (g !== 1'b0 || r !== 32'h0000_0006) begin
      errors++;
      $display("FAIL midop_tie: granted %0d data=%h expected 0 00000006", g, r);
    end
  endtask

  task automatic test_zero_amount();
    bit g; int c; logic [31:0] r;
    issue(1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 0, g, c, r);
    idle_inputs();
    checks++;
    if (r !== 32'h1234_5678) begin
      errors++;
      $display("FAIL zero_amount: data=%h expected 12345678", r);
    end
  endtask

  task automatic test_random();
    bit g; int c; logic [31:0] r;
    bit v0; bit v1;
    logic [4:0] a0; logic [4:0] a1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      issue(v0, v1, $urandom, $urandom, a0, a1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), g, c, r);
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_left();
    test_asr();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_zero_amount();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
